bf_dmem_arbiter: RTL and testbench

Two-port arbiter that shares the Brainfuck CPU's single data memory controller (DMEMC) between the CPU data port and a host/debug port used for tape preload and dump. Each requester sees the same level-request / done-pulse protocol that DMEMC itself presents. The arbiter serialises transactions with round-robin priority and holds a grant for the whole memory transaction. A response-timeout watchdog aborts hung transactions so the CPU is never locked out.

---
 rtl/bf_pkg.sv | 23 ++
 rtl/bf_rr_pick2.sv | 23 ++
 rtl/bf_dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_bf_dmem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared types and widths for the Brainfuck CPU memory-side blocks.
// Requester ids, arbiter states and memory op kinds live here.
package bf_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef enum logic {
        REQ_CPU,
        REQ_HOST
    } req_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

endpackage

// File: rtl/bf_rr_pick2.sv
// Two-way round-robin pick: a lone pending requester wins,
// on a tie the one that was not served last wins.
module bf_rr_pick2
    import bf_pkg::*;
(
    input  logic [1:0] pend,
    input  req_t       last,
    output req_t       gnt,
    output logic       gnt_v
);

    always_comb begin
        gnt   = REQ_CPU;
        gnt_v = |pend;
        unique case (pend)
            2'b01:   gnt = REQ_CPU;
            2'b10:   gnt = REQ_HOST;
            2'b11:   gnt = (last == REQ_CPU) ? REQ_HOST : REQ_CPU;
            default: gnt = REQ_CPU;
        endcase
    end

endmodule

// File: rtl/bf_dmem_arbiter.sv
// Shares the single DMEMC between the CPU data port and the host port,
// one whole transaction per grant, with a response-timeout abort.
module bf_dmem_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = bf_pkg::ADDR_W,
    parameter int DATA_W  = bf_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rf,
    output logic              cpu_wf,
    output logic              cpu_err,
    input  logic              host_rd,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rf,
    output logic              host_wf,
    output logic              host_err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rf,
    input  logic              mem_wf
);
    import bf_pkg::*;

    state_t      state;
    req_t        owner;
    req_t        last;
    req_t        gnt;
    op_t         op;
    logic [7:0]  tmo;
    logic        gnt_v;
    logic        done;
    logic        expired;

    bf_rr_pick2 u_pick (
        .pend  ({host_rd | host_wr, cpu_rd | cpu_wr}),
        .last  (last),
        .gnt   (gnt),
        .gnt_v (gnt_v)
    );

    // Only the completion kind matching the issued op ends a transaction.
    always_comb begin
        done    = (op == OP_RD) ? mem_rf : mem_wf;
        expired = (tmo == 8'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= REQ_CPU;
            last       <= REQ_HOST;
            op         <= OP_RD;
            tmo        <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            cpu_rf     <= 1'b0;
            cpu_wf     <= 1'b0;
            cpu_err    <= 1'b0;
            host_rdata <= '0;
            host_rf    <= 1'b0;
            host_wf    <= 1'b0;
            host_err   <= 1'b0;
        end else begin
            cpu_rf   <= 1'b0;
            cpu_wf   <= 1'b0;
            cpu_err  <= 1'b0;
            host_rf  <= 1'b0;
            host_wf  <= 1'b0;
            host_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gnt_v) begin
                        state <= BUSY;
                        owner <= gnt;
                        last  <= gnt;
                        tmo   <= '0;
                        if (gnt == REQ_CPU) begin
                            op        <= cpu_wr ? OP_WR : OP_RD;
                            mem_rd    <= ~cpu_wr;
                            mem_wr    <= cpu_wr;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end else begin
                            op        <= host_wr ? OP_WR : OP_RD;
                            mem_rd    <= ~host_wr;
                            mem_wr    <= host_wr;
                            mem_addr  <= host_addr;
                            mem_wdata <= host_wdata;
                        end
                    end
                end
                BUSY: begin
                    // Completion beats a same-cycle timeout.
                    if (done || expired) begin
                        state  <= IDLE;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (owner == REQ_CPU) begin
                            cpu_rf  <= (op == OP_RD);
                            cpu_wf  <= (op == OP_WR);
                            cpu_err <= ~done;
                            if (op == OP_RD)
                                cpu_rdata <= done ? mem_rdata : '0;
                        end else begin
                            host_rf  <= (op == OP_RD);
                            host_wf  <= (op == OP_WR);
                            host_err <= ~done;
                            if (op == OP_RD)
                                host_rdata <= done ? mem_rdata : '0;
                        end
                    end else begin
                        tmo <= tmo + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bf_dmem_arbiter.sv
// Bench for bf_dmem_arbiter: directed scenarios plus random traffic
// against a transaction-level reference kept in the bench.
module tb_bf_dmem_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_rd = 0, cpu_wr = 0;
    logic [14:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_rf, cpu_wf, cpu_err;
    logic        host_rd = 0, host_wr = 0;
    logic [14:0] host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic [7:0]  host_rdata;
    logic        host_rf, host_wf, host_err;
    logic        mem_rd, mem_wr;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_rf = 0, mem_wf = 0;

    int n_chk = 0;
    int n_fail = 0;

    bf_dmem_arbiter #(.TIMEOUT(TMO), .ADDR_W(15), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_rf(cpu_rf), .cpu_wf(cpu_wf), .cpu_err(cpu_err),
        .host_rd(host_rd), .host_wr(host_wr), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_rf(host_rf), .host_wf(host_wf), .host_err(host_err),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rf(mem_rf), .mem_wf(mem_wf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // DMEMC stand-in: fixed or random latency, optional stray pulses.
    bit        rand_mode = 0;
    bit        inject_rf = 0;
    int        fix_lat = 2;
    logic [7:0] fix_data = 8'h00;
    int        d_cnt = 0;
    int        d_lat = 0;

    always @(posedge clk) begin
        #3;
        mem_rf = 0;
        mem_wf = 0;
        if (mem_rd || mem_wr) begin
            d_cnt++;
            if (d_cnt == 1)
                d_lat = !rand_mode ? fix_lat :
                        ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 5));
            if (d_cnt == d_lat) begin
                mem_rdata = rand_mode ? 8'($urandom) : fix_data;
                if (mem_rd) mem_rf = 1; else mem_wf = 1;
            end else if (rand_mode && $urandom_range(0, 7) == 0) begin
                if (mem_rd) mem_wf = 1; else mem_rf = 1;
            end
        end else begin
            d_cnt = 0;
            if (inject_rf) mem_rf = 1;
            else if (rand_mode && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) mem_rf = 1; else mem_wf = 1;
            end
        end
    end

    // Reference: one transaction at a time, decided from the rules directly.
    bit         m_valid = 0;
    bit         m_busy = 0;
    int         m_own = 0;
    int         m_last = 1;
    int         m_age = 0;
    bit         m_iswr = 0;
    bit         m_ok;
    bit         m_pc, m_ph;
    int         m_who;
    bit         m_cmd_rd = 0, m_cmd_wr = 0;
    logic [14:0] m_addr = '0;
    logic [7:0] m_wdata = '0;
    bit         m_rf [2];
    bit         m_wf [2];
    bit         m_err [2];
    logic [7:0] m_rdata [2];

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            m_rf[s] = 0; m_wf[s] = 0; m_err[s] = 0;
        end
        if (reset) begin
            m_valid = 1; m_busy = 0; m_last = 1;
            m_cmd_rd = 0; m_cmd_wr = 0;
            m_rdata[0] = 0; m_rdata[1] = 0;
        end else if (!m_busy) begin
            m_pc = cpu_rd | cpu_wr;
            m_ph = host_rd | host_wr;
            m_who = -1;
            if (m_pc && m_ph) m_who = (m_last == 0) ? 1 : 0;
            else if (m_pc) m_who = 0;
            else if (m_ph) m_who = 1;
            if (m_who >= 0) begin
                m_busy = 1; m_own = m_who; m_last = m_who; m_age = 0;
                m_iswr = (m_who == 0) ? cpu_wr : host_wr;
                m_addr = (m_who == 0) ? cpu_addr : host_addr;
                m_wdata = (m_who == 0) ? cpu_wdata : host_wdata;
                m_cmd_rd = !m_iswr; m_cmd_wr = m_iswr;
            end
        end else begin
            m_age++;
            m_ok = m_iswr ? mem_wf : mem_rf;
            if (m_ok || m_age == TMO) begin
                m_busy = 0; m_cmd_rd = 0; m_cmd_wr = 0;
                m_rf[m_own] = !m_iswr;
                m_wf[m_own] = m_iswr;
                m_err[m_own] = !m_ok;
                if (!m_iswr) m_rdata[m_own] = m_ok ? mem_rdata : 8'h00;
            end
        end
        #1;
        if (m_valid) begin
            chk("mem_rd", mem_rd, m_cmd_rd);
            chk("mem_wr", mem_wr, m_cmd_wr);
            if (m_cmd_rd || m_cmd_wr) begin
                chk("mem_addr", mem_addr, m_addr);
                if (m_cmd_wr) chk("mem_wdata", mem_wdata, m_wdata);
            end
            chk("cpu_done", {cpu_rf, cpu_wf, cpu_err}, {m_rf[0], m_wf[0], m_err[0]});
            chk("host_done", {host_rf, host_wf, host_err}, {m_rf[1], m_wf[1], m_err[1]});
            chk("cpu_rdata", cpu_rdata, m_rdata[0]);
            chk("host_rdata", host_rdata, m_rdata[1]);
        end
    end

    // Requester side helpers.
    bit done_c, done_h;
    int cmd_cyc = 0;
    int log_q[$];

    task automatic tick();
        @(negedge clk);
        done_c = cpu_rf | cpu_wf;
        done_h = host_rf | host_wf;
        if (done_c) begin cpu_rd = 0; cpu_wr = 0; log_q.push_back(0); end
        if (done_h) begin host_rd = 0; host_wr = 0; log_q.push_back(1); end
        if (mem_rd || mem_wr) cmd_cyc++;
    endtask

    task automatic wait_done(input int side, input string nm);
        bit hit = 0;
        for (int k = 0; k < 60 && !hit; k++) begin
            tick();
            hit = (side == 0) ? done_c : done_h;
        end
        if (!hit) chk({nm, "_no_done"}, 0, 1);
    endtask

    task automatic do_reset();
        reset = 1;
        cpu_rd = 0; cpu_wr = 0; host_rd = 0; host_wr = 0;
        tick();
        reset = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    int k;
    bit anyd;

    initial begin
        tick();
        do_reset();
        chk("rst_cmd", {mem_rd, mem_wr}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_pulses", {cpu_rf, cpu_wf, cpu_err, host_rf, host_wf, host_err}, 0);
        chk("rst_rdata", {cpu_rdata, host_rdata}, 0);

        // CPU read, DMEMC answers 3 cycles later.
        fix_lat = 3; fix_data = 8'hA5;
        cpu_addr = 15'h0010; cpu_rd = 1; cmd_cyc = 0;
        tick();
        chk("t1_mem_rd", mem_rd, 1);
        chk("t1_mem_addr", mem_addr, 15'h0010);
        wait_done(0, "t1");
        chk("t1_rf", {cpu_rf, cpu_wf, cpu_err}, 3'b100);
        chk("t1_rdata", cpu_rdata, 8'hA5);
        chk("t1_cmd_cycles", cmd_cyc, 3);
        repeat (3) tick();

        // Contention from reset: CPU first, then strict alternation.
        do_reset();
        fix_lat = 2; fix_data = 8'h77;
        log_q.delete();
        cpu_addr = 15'h0001; host_addr = 15'h0002;
        cpu_rd = 1; host_rd = 1;
        for (int i = 0; i < 200 && log_q.size() < 8; i++) begin
            tick();
            if (!done_c && !cpu_rd) cpu_rd = 1;
            if (!done_h && !host_rd) host_rd = 1;
        end
        cpu_rd = 0; host_rd = 0;
        chk("t2_count", log_q.size() >= 8, 1);
        for (int i = 0; i < 8 && i < log_q.size(); i++)
            chk($sformatf("t2_order%0d", i), log_q[i], i % 2);
        repeat (10) tick();
        chk("t2_host_rdata", host_rdata, 8'h77);

        // Host write arrives while CPU busy.
        fix_lat = 3;
        cpu_addr = 15'h0005; cpu_rd = 1;
        tick();
        host_addr = 15'h7FFF; host_wdata = 8'h3C; host_wr = 1;
        wait_done(0, "t3cpu");
        chk("t3_gap", {mem_rd, mem_wr}, 2'b00);
        tick();
        chk("t3_host_cmd", {mem_rd, mem_wr}, 2'b01);
        chk("t3_host_addr", mem_addr, 15'h7FFF);
        chk("t3_host_wdata", mem_wdata, 8'h3C);
        wait_done(1, "t3host");
        chk("t3_host_wf", {host_rf, host_wf, host_err}, 3'b010);
        repeat (2) tick();

        // DMEMC hangs: abort after TMO cycles.
        fix_lat = -1;
        host_addr = 15'h0100; host_rd = 1; cmd_cyc = 0;
        wait_done(1, "t4");
        chk("t4_abort", {host_rf, host_wf, host_err}, 3'b101);
        chk("t4_rdata", host_rdata, 8'h00);
        chk("t4_cmd_cycles", cmd_cyc, TMO);
        fix_lat = 2; fix_data = 8'h5A;
        cpu_addr = 15'h0200; cpu_rd = 1;
        wait_done(0, "t4cpu");
        chk("t4_cpu_ok", {cpu_rf, cpu_err, cpu_rdata}, {2'b10, 8'h5A});
        repeat (2) tick();

        // Reset mid-transaction, then a stale completion.
        fix_lat = -1;
        cpu_rd = 1;
        tick(); tick();
        do_reset();
        chk("t5_cmd", {mem_rd, mem_wr}, 0);
        chk("t5_rdata", cpu_rdata, 0);
        inject_rf = 1;
        tick();
        inject_rf = 0;
        anyd = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            anyd = anyd | done_c | done_h;
        end
        chk("t5_no_done", anyd, 0);
        fix_lat = 2;
        log_q.delete();
        cpu_rd = 1; host_rd = 1;
        wait_done(0, "t5cpu");
        chk("t5_first", log_q.size() > 0 ? log_q[0] : -1, 0);
        wait_done(1, "t5host");
        repeat (2) tick();

        // rd and wr together behave as a write.
        fix_lat = 2;
        cpu_addr = 15'h0033; cpu_wdata = 8'hC3; cpu_rd = 1; cpu_wr = 1;
        tick();
        chk("t6_cmd", {mem_rd, mem_wr}, 2'b01);
        wait_done(0, "t6");
        chk("t6_done", {cpu_rf, cpu_wf, cpu_err}, 3'b010);
        repeat (2) tick();

        // Random traffic.
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset = ($urandom_range(0, 599) == 0);
            if (!done_c) begin
                if (!(cpu_rd | cpu_wr)) begin
                    if ($urandom_range(0, 3) == 0) begin
                        k = $urandom_range(0, 2);
                        cpu_rd = (k != 1); cpu_wr = (k != 0);
                        cpu_addr = 15'($urandom); cpu_wdata = 8'($urandom);
                    end
                end else if ($urandom_range(0, 59) == 0) begin
                    cpu_rd = 0; cpu_wr = 0;
                end
            end
            if (!done_h) begin
                if (!(host_rd | host_wr)) begin
                    if ($urandom_range(0, 3) == 0) begin
                        k = $urandom_range(0, 2);
                        host_rd = (k != 1); host_wr = (k != 0);
                        host_addr = 15'($urandom); host_wdata = 8'($urandom);
                    end
                end else if ($urandom_range(0, 59) == 0) begin
                    host_rd = 0; host_wr = 0;
                end
            end
        end
        rand_mode = 0;
        reset = 0;
        cpu_rd = 0; cpu_wr = 0; host_rd = 0; host_wr = 0;
        fix_lat = 1;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
